// File: rtl/fetch_unit.sv
// Instruction fetch front end: program counter, instruction pass-through and
// a return-address stack for call/return, driven by controller strobes.
module fetch_unit #(
  parameter int INSTR_W = 19,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enablePC,
  input  logic                       jump,
  input  logic                       push,
  input  logic                       RET,
  input  logic [INSTR_W-1:0]         imem_data,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [INSTR_W-1:0]         allBits,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH):0]     stack_count,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] retStack [DEPTH];
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pcInc;
  logic [PTR_W-1:0]  wrIdx;
  logic [PTR_W-1:0]  topIdx;
  logic              doPush;

  assign allBits     = imem_data;
  assign imem_addr   = pc;
  assign target      = allBits[ADDR_W-1:0];
  assign pcInc       = pc + ADDR_W'(1);
  assign stack_full  = (stack_count == CNT_W'(DEPTH));
  assign stack_empty = (stack_count == '0);

  // The count doubles as the LIFO pointer; when full its low bits wrap to 0,
  // but no write happens then, so the wrap is harmless.
  assign wrIdx  = stack_count[PTR_W-1:0];
  assign topIdx = wrIdx - PTR_W'(1);

  // A call only writes when the stack has room and RET is not also asserted.
  assign doPush = enablePC && !RET && push && !stack_full;

  always_ff @(posedge clk) begin
    if (!rst && doPush) begin
      retStack[wrIdx] <= pcInc;
    end
  end

  // One action per enabled edge, priority RET > push > jump > increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      stack_count <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (enablePC) begin
      if (RET) begin
        if (!stack_empty) begin
          pc          <= retStack[topIdx];
          stack_count <= stack_count - CNT_W'(1);
        end else begin
          pc        <= pcInc;
          underflow <= 1'b1;
        end
      end else if (push) begin
        if (!stack_full) begin
          pc          <= target;
          stack_count <= stack_count + CNT_W'(1);
        end else begin
          pc       <= pcInc;
          overflow <= 1'b1;
        end
      end else if (jump) begin
        pc <= target;
      end else begin
        pc <= pcInc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven vectors plus a modelled
// nested-call sequence that exercises full, overflow and underflow.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        enablePC;
  logic        jump;
  logic        push;
  logic        RET;
  logic [18:0] imem_data;
  logic [11:0] imem_addr;
  logic [18:0] allBits;
  logic [11:0] pc;
  logic [3:0]  stack_count;
  logic        stack_full;
  logic        stack_empty;
  logic        overflow;
  logic        underflow;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        jmp;
    logic        psh;
    logic        ret;
    logic [11:0] tgt;
    logic [11:0] expPc;
    logic [3:0]  expCnt;
    logic        expOvf;
    logic        expUdf;
  } vec_t;

  vec_t vecs[$];
  int   vectorCount;
  int   missCount;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .enablePC   (enablePC),
    .jump       (jump),
    .push       (push),
    .RET        (RET),
    .imem_data  (imem_data),
    .imem_addr  (imem_addr),
    .allBits    (allBits),
    .pc         (pc),
    .stack_count(stack_count),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic r, input logic en,
                        input logic jm, input logic ps, input logic rt,
                        input logic [11:0] tgt, input logic [11:0] ePc,
                        input logic [3:0] eCnt, input logic eOvf, input logic eUdf);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.jmp = jm; v.psh = ps; v.ret = rt;
    v.tgt = tgt; v.expPc = ePc; v.expCnt = eCnt; v.expOvf = eOvf; v.expUdf = eUdf;
    vecs.push_back(v);
  endtask

  // Drive inputs, let one rising edge act on them, then settle before sampling.
  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    enablePC  = v.en;
    jump      = v.jmp;
    push      = v.psh;
    RET       = v.ret;
    imem_data = {7'(vectorCount + 7'h15), v.tgt};
    @(posedge clk);
    #1;
    imem_data = {7'h2A, 12'h5A5};
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic expFull;
    logic expEmpty;
    expFull  = (v.expCnt == 4'd8);
    expEmpty = (v.expCnt == 4'd0);
    vectorCount++;
    if (pc !== v.expPc || stack_count !== v.expCnt || overflow !== v.expOvf ||
        underflow !== v.expUdf || stack_full !== expFull || stack_empty !== expEmpty ||
        imem_addr !== v.expPc || allBits !== {7'h2A, 12'h5A5}) begin
      missCount++;
      $display("[TB] FAIL %s: got pc=%h cnt=%0d full=%b empty=%b ovf=%b udf=%b addr=%h bits=%h, want pc=%h cnt=%0d full=%b empty=%b ovf=%b udf=%b addr=%h bits=%h",
               v.name, pc, stack_count, stack_full, stack_empty, overflow, underflow,
               imem_addr, allBits, v.expPc, v.expCnt, expFull, expEmpty, v.expOvf,
               v.expUdf, v.expPc, {7'h2A, 12'h5A5});
    end
  endtask

  task automatic runTable();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] modelPc;
    logic [11:0] modelStack[$];
    logic [11:0] tgt;
    vec_t        v;

    vectorCount = 0;
    missCount   = 0;
    rst = 1'b0; enablePC = 1'b0; jump = 1'b0; push = 1'b0; RET = 1'b0;
    imem_data = '0;

    //       name           rst en jmp psh ret tgt     pc      cnt ovf udf
    addVec("reset",         1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0);
    addVec("inc1",          0, 1, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0);
    addVec("inc2",          0, 1, 0, 0, 0, 12'h000, 12'h002, 0, 0, 0);
    addVec("inc3",          0, 1, 0, 0, 0, 12'h000, 12'h003, 0, 0, 0);
    addVec("call040",       0, 1, 0, 1, 0, 12'h040, 12'h040, 1, 0, 0);
    addVec("inc41",         0, 1, 0, 0, 0, 12'h000, 12'h041, 1, 0, 0);
    addVec("inc42",         0, 1, 0, 0, 0, 12'h000, 12'h042, 1, 0, 0);
    addVec("ret4",          0, 1, 0, 0, 1, 12'h000, 12'h004, 0, 0, 0);
    addVec("jumpFFF",       0, 1, 1, 0, 0, 12'hFFF, 12'hFFF, 0, 0, 0);
    addVec("wrap",          0, 1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0);
    addVec("holdJump",      0, 0, 1, 0, 0, 12'h123, 12'h000, 0, 0, 0);
    addVec("holdRet",       0, 0, 0, 0, 1, 12'h123, 12'h000, 0, 0, 0);
    addVec("holdPush",      0, 0, 0, 1, 0, 12'h234, 12'h000, 0, 0, 0);
    addVec("call010",       0, 1, 0, 1, 0, 12'h010, 12'h010, 1, 0, 0);
    addVec("jump01F",       0, 1, 1, 0, 0, 12'h01F, 12'h01F, 1, 0, 0);
    addVec("call050",       0, 1, 0, 1, 0, 12'h050, 12'h050, 2, 0, 0);
    addVec("retWithPush",   0, 1, 0, 1, 1, 12'h077, 12'h020, 1, 0, 0);
    addVec("pushWithJump",  0, 1, 1, 1, 0, 12'h060, 12'h060, 2, 0, 0);
    addVec("ret021",        0, 1, 0, 0, 1, 12'h000, 12'h021, 1, 0, 0);
    addVec("ret001",        0, 1, 0, 0, 1, 12'h000, 12'h001, 0, 0, 0);
    runTable();

    // Eight nested calls, one refused call, eight returns and one extra return.
    modelPc = 12'h001;
    for (int k = 0; k < 8; k++) begin
      tgt = (k == 7) ? 12'h100 : 12'(12'h200 + k * 12'h010);
      modelStack.push_back(modelPc + 12'h001);
      modelPc = tgt;
      v = '{"nestCall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, tgt, modelPc,
            4'(modelStack.size()), 1'b0, 1'b0};
      applyStimulus(v);
      checkOutput(v);
    end
    modelPc = modelPc + 12'h001;
    v = '{"pushWhenFull", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h300, modelPc, 4'd8, 1'b1, 1'b0};
    applyStimulus(v);
    checkOutput(v);
    for (int k = 0; k < 8; k++) begin
      modelPc = modelStack.pop_back();
      v = '{"nestRet", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, modelPc,
            4'(modelStack.size()), 1'b1, 1'b0};
      applyStimulus(v);
      checkOutput(v);
    end
    modelPc = modelPc + 12'h001;
    v = '{"retWhenEmpty", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, modelPc, 4'd0, 1'b1, 1'b1};
    applyStimulus(v);
    checkOutput(v);

    //       name           rst en jmp psh ret tgt     pc      cnt ovf udf
    addVec("call400",       0, 1, 0, 1, 0, 12'h400, 12'h400, 1, 1, 1);
    addVec("call410",       0, 1, 0, 1, 0, 12'h410, 12'h410, 2, 1, 1);
    addVec("call420",       0, 1, 0, 1, 0, 12'h420, 12'h420, 3, 1, 1);
    addVec("resetMidCall",  1, 1, 0, 1, 0, 12'h500, 12'h000, 0, 0, 0);
    addVec("incAfterReset", 0, 1, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0);
    runTable();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-supply end of the controller interface: holds the program counter and drives the 19-bit instruction word `allBits` into the controller.
- Consumes the controller's `enablePC`, `push` and `RET` strobes plus an external `jump` strobe.
- Contains a hardware return-address stack for call/return.
- Sits between instruction memory (combinational read) and the controller.

Parameters:
- INSTR_W, 19, instruction word width.
- ADDR_W, 12, PC / instruction-memory address width. Jump target is `allBits[ADDR_W-1:0]`.
- DEPTH, 8, return-stack entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enablePC  input  1  from controller; when 0, PC and stack hold.
- jump  input  1  load PC with target this cycle.
- push  input  1  call: save PC+1 on stack, load PC with target.
- RET  input  1  return: pop stack top into PC.
- imem_data  input  INSTR_W  word read from instruction memory at `imem_addr`.
- imem_addr  output  ADDR_W  equals PC (combinational from PC register).
- allBits  output  INSTR_W  current instruction to controller; combinational copy of `imem_data`.
- pc  output  ADDR_W  PC register.
- stack_count  output  log2(DEPTH)+1  occupied entries, 0..DEPTH.
- stack_full  output  1  `stack_count == DEPTH`.
- stack_empty  output  1  `stack_count == 0`.
- overflow  output  1  sticky; set by push while full.
- underflow  output  1  sticky; set by RET while empty.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=0, stack_count=0, overflow=0, underflow=0.
  - Stack contents are don't-care.
  - Reset overrides every other input in that cycle, including mid call/return sequences.
- Derived signals:
  - `target = allBits[ADDR_W-1:0]`, sampled in the same cycle as the strobe.
  - `pc_inc = pc + 1`, modulo 2^ADDR_W; 4095 wraps to 0 at the default width.
- enablePC=0: pc, stack, count and flags all hold; `jump`, `push` and `RET` are ignored with no flag effects.
- enablePC=1: exactly one action per edge, chosen by priority `RET > push > jump > increment`:
  - RET, count>0: pc <= stack[count-1]; count--.
  - RET, count==0: pc <= pc_inc; underflow <= 1; count unchanged.
  - push (RET=0), count<DEPTH: stack[count] <= pc_inc; count++; pc <= target.
  - push (RET=0), count==DEPTH: no write; pc <= pc_inc; overflow <= 1.
  - jump only: pc <= target; stack untouched.
  - none: pc <= pc_inc.
- Simultaneous strobes:
  - RET with push: RET executes, push is dropped, no overflow.
  - push with jump: push (call) executes.
- Sticky flags clear only on rst.
- Latency:
  - New pc is visible one cycle after the strobe edge.
  - allBits follows imem_data with zero latency, so an instruction reaches the controller in the same cycle pc changes.
- Stack is a LIFO addressed by count. No read-before-write hazard exists because push and pop never execute in the same cycle.

Test Plan:
1. rst=1 for 1 cycle, then enablePC=1 for 5 cycles with no strobes -> pc sequence 0,1,2,3,4,5; imem_addr==pc; stack_empty=1.
2. At pc=3 with allBits[11:0]=0x040, assert push -> next pc=0x040, stack_count=1, stack[0]=4. Two increments later assert RET -> pc=4, stack_count=0, stack_empty=1.
3. Nest 8 calls, then a 9th push at pc=0x100 -> stack_full=1, overflow=1, pc=0x101, count stays 8. Then 8 RETs return in LIFO order. A 9th RET -> underflow=1, pc increments.
4. jump with target 0xFFF, then one increment -> pc=0xFFF then 0x000 (wrap). enablePC=0 with jump=1 for 3 cycles -> pc holds at 0x000.
5. RET and push together with count=2 (top=0x020) -> pc=0x020, count=1, overflow=0. push and jump together -> call behaviour, count increments.
6. Assert rst mid-sequence with count=3 and overflow=1 -> next cycle pc=0, count=0, overflow=0, underflow=0.
